request_issuer: RTL and testbench

Requester-side front end for the round-robin grant path. It accumulates per-port pending-request counts, presents a request vector and enable to the one-hot selector, and consumes the returned one-hot grant. On each accepted grant it retires one pending request and reports the granted port index one cycle later. It sits between the client ports and the arbiter, owning all request state that the combinational selector does not hold.

---
 rtl/request_issuer.sv | 108 ++++++++++
 tb/tb_request_issuer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/request_issuer.sv
// rtl/request_issuer.sv - per-port pending-request tracker feeding a one-hot grant selector
// Optional build macro: GRANT_CHECK_EN (adds sel protocol checker driving err)
module request_issuer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] push,
  input  logic             hold,
  output logic [WIDTH-1:0] requests,
  output logic             en,
  input  logic [WIDTH-1:0] sel,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_id,
  output logic             overflow,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count [WIDTH];
  logic [WIDTH-1:0] accept_raw;
  logic [WIDTH-1:0] accept;
  logic [IDX_W-1:0] low_idx;

  // A port is requesting whenever it still holds pending credit.
  always_comb begin
    requests = '0;
    for (int i = 0; i < WIDTH; i++) begin
      requests[i] = (count[i] != '0);
    end
  end

  assign en         = ~hold & (|requests);
  assign accept_raw = sel & requests & {WIDTH{en}};

`ifdef GRANT_CHECK_EN
  logic chk_err;

  // A bad sel (multi-hot, grant to an idle port, or grant while disabled) is rejected outright.
  always_comb begin
    chk_err = 1'b0;
    if ((sel & (sel - 1'b1)) != '0) chk_err = 1'b1;
    if ((sel & ~requests) != '0)    chk_err = 1'b1;
    if ((sel != '0) && !en)         chk_err = 1'b1;
  end

  assign accept = chk_err ? '0 : accept_raw;

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (chk_err) begin
      err <= 1'b1;
    end
  end
`else
  assign accept = accept_raw;
  assign err    = 1'b0;
`endif

  // Lowest accepted index wins the report when several ports are accepted together.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (accept[i]) low_idx = IDX_W'(i);
    end
  end

  // Per-port saturating credit counters plus the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        count[i] <= '0;
      end
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (push[i] && !accept[i]) begin
          if (count[i] == CNT_MAX) begin
            overflow <= 1'b1;
          end else begin
            count[i] <= count[i] + 1'b1;
          end
        end else if (accept[i] && !push[i]) begin
          count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

  // Report the accepted grant one cycle later; grant_id keeps its last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      grant_valid <= |accept;
      if (|accept) begin
        grant_id <= low_idx;
      end
    end
  end

endmodule

// File: tb/tb_request_issuer.sv
// tb/tb_request_issuer.sv - directed self-checking bench for request_issuer
module tb_request_issuer;

  logic       clk;
  logic       rst_n;
  logic [3:0] push;
  logic       hold;
  logic [3:0] requests;
  logic       en;
  logic [3:0] sel;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       overflow;
  logic       err;

  int passed;
  int total;

  request_issuer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .hold       (hold),
    .requests   (requests),
    .en         (en),
    .sel        (sel),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .overflow   (overflow),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    push   = '0;
    hold   = 1'b0;
    sel    = '0;
    #2;
    // Reset state
    chk("rst_requests", 32'(requests), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_gv", 32'(grant_valid), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Push ports 0 and 2
    push = 4'b0101;
    step();
    push = 4'b0000;
    chk("push_requests", 32'(requests), 32'h5);
    chk("push_en", 32'(en), 32'h1);
    chk("push_cnt0", 32'(dut.count[0]), 32'd1);
    chk("push_cnt1", 32'(dut.count[1]), 32'd0);
    chk("push_cnt2", 32'(dut.count[2]), 32'd1);
    chk("push_cnt3", 32'(dut.count[3]), 32'd0);
    chk("push_gv", 32'(grant_valid), 32'h0);

    // Grant port 2
    sel = 4'b0100;
    step();
    sel = 4'b0000;
    chk("g2_cnt2", 32'(dut.count[2]), 32'd0);
    chk("g2_requests", 32'(requests), 32'h1);
    chk("g2_gv", 32'(grant_valid), 32'h1);
    chk("g2_gid", 32'(grant_id), 32'd2);
    step();
    chk("g2_gv_drop", 32'(grant_valid), 32'h0);
    chk("g2_gid_hold", 32'(grant_id), 32'd2);

    // Last pending request granted: requests and en fall next cycle
    sel = 4'b0001;
    step();
    sel = 4'b0000;
    chk("g0_requests", 32'(requests), 32'h0);
    chk("g0_en", 32'(en), 32'h0);
    chk("g0_gv", 32'(grant_valid), 32'h1);
    chk("g0_gid", 32'(grant_id), 32'd0);

    // Saturate port 1
    push = 4'b0010;
    for (int k = 0; k < 7; k++) step();
    chk("sat_cnt1", 32'(dut.count[1]), 32'd7);
    chk("sat_ovf0", 32'(overflow), 32'h0);
    step();
    chk("ovf_cnt1", 32'(dut.count[1]), 32'd7);
    chk("ovf_flag", 32'(overflow), 32'h1);
    sel = 4'b0010;
    step();
    push = 4'b0000;
    sel  = 4'b0000;
    chk("pushsel_cnt1", 32'(dut.count[1]), 32'd7);
    chk("pushsel_gv", 32'(grant_valid), 32'h1);
    chk("pushsel_gid", 32'(grant_id), 32'd1);

    // hold blocks acceptance
    push = 4'b1000;
    step();
    step();
    push = 4'b0000;
    chk("hold_pre_cnt3", 32'(dut.count[3]), 32'd2);
    hold = 1'b1;
    sel  = 4'b1000;
    #1;
    chk("hold_en", 32'(en), 32'h0);
    step();
    chk("hold_cnt3", 32'(dut.count[3]), 32'd2);
    chk("hold_gv", 32'(grant_valid), 32'h0);
`ifdef GRANT_CHECK_EN
    chk("hold_err", 32'(err), 32'h1);
`else
    chk("hold_err", 32'(err), 32'h0);
`endif
    hold = 1'b0;
    sel  = 4'b0000;

    // Multi-bit sel with counts {1,1,0,0}
    do_reset();
    chk("mb_rst_err", 32'(err), 32'h0);
    chk("mb_rst_ovf", 32'(overflow), 32'h0);
    push = 4'b0011;
    step();
    push = 4'b0000;
    sel  = 4'b0011;
    step();
    sel  = 4'b0000;
`ifdef GRANT_CHECK_EN
    chk("mb_err", 32'(err), 32'h1);
    chk("mb_cnt0", 32'(dut.count[0]), 32'd1);
    chk("mb_cnt1", 32'(dut.count[1]), 32'd1);
    chk("mb_gv", 32'(grant_valid), 32'h0);
`else
    chk("mb_err", 32'(err), 32'h0);
    chk("mb_cnt0", 32'(dut.count[0]), 32'd0);
    chk("mb_cnt1", 32'(dut.count[1]), 32'd0);
    chk("mb_gv", 32'(grant_valid), 32'h1);
    chk("mb_gid", 32'(grant_id), 32'd0);
`endif

    // Async reset mid-operation with counts {3,2,0,1} then a grant in flight
    do_reset();
    push = 4'b1011;
    step();
    push = 4'b0011;
    step();
    push = 4'b0001;
    step();
    push = 4'b0000;
    chk("ar_cnt0", 32'(dut.count[0]), 32'd3);
    chk("ar_cnt1", 32'(dut.count[1]), 32'd2);
    chk("ar_cnt3", 32'(dut.count[3]), 32'd1);
    chk("ar_requests", 32'(requests), 32'hB);
    sel = 4'b0001;
    step();
    sel = 4'b0000;
    chk("ar_gv_pre", 32'(grant_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_requests0", 32'(requests), 32'h0);
    chk("ar_en0", 32'(en), 32'h0);
    chk("ar_gv0", 32'(grant_valid), 32'h0);
    chk("ar_gid0", 32'(grant_id), 32'h0);
    chk("ar_cnt0_0", 32'(dut.count[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("ar_post_requests", 32'(requests), 32'h0);
    chk("ar_post_en", 32'(en), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
